// File: rtl/seg_pkg.sv
// Shared constants and types for the seven-segment scanner: segment codes,
// digit index type, scan phase and decimal-point placement.
package seg_pkg;

  localparam int NUM_DIGITS = 8;

  // Active-low segment codes, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef logic [2:0] digit_t;

  typedef enum logic {
    PH_BLANK,
    PH_DRIVE
  } phase_t;

  // Digits whose decimal point is lit: S.ff, M.S and H.M separators
  localparam logic [7:0] DP_MASK = 8'b0101_0100;

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD nibble to active-low seven-segment decoder; any
// non-decimal nibble shows a dash.
module bcd_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg_scan.sv
// Eight-digit multiplexed seven-segment scanner showing HH MM SS.ff from a
// per-frame snapshot. Define SEG_LZB_EN to blank a leading zero in hour tens.
module seg_scan
  import seg_pkg::*;
#(
  parameter int SCAN_DIV  = 1000,
  parameter int BLANK_CYC = 2
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [23:0] sec,
  input  logic [7:0]  min,
  input  logic [7:0]  hr,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame
);

  localparam logic [15:0] CNT_MAX  = 16'(SCAN_DIV - 1);
  localparam logic [15:0] CNT_BLNK = 16'(BLANK_CYC);

  logic [15:0] cnt;
  logic [15:0] cntNext;
  digit_t      d;
  digit_t      dNext;
  logic [31:0] snap;
  logic        load;
  logic        hideD7;
  logic        hideNow;
  phase_t      phaseNext;
  logic [3:0]  nibble;
  logic [6:0]  decoded;
  logic [6:0]  segNext;
  logic [7:0]  anNext;

`ifdef SEG_LZB_EN
  assign hideD7 = (snap[31:28] == 4'h0);
`else
  assign hideD7 = 1'b0;
`endif

  // Everything registered is derived from the state being entered, so the
  // outputs line up with cnt/d on the same edge.
  always_comb begin
    cntNext   = cnt + 16'd1;
    dNext     = d;
    load      = 1'b0;
    if (cnt == CNT_MAX) begin
      cntNext = 16'd0;
      dNext   = digit_t'(d + 3'd1);
      load    = (d == 3'd7);
    end
    phaseNext = (cntNext < CNT_BLNK) ? PH_BLANK : PH_DRIVE;
    hideNow   = (dNext == 3'd7) && hideD7;
    nibble    = snap[{dNext, 2'b00} +: 4];
    segNext   = hideNow ? SEG_BLANK : decoded;
    anNext    = 8'hFF;
    if (phaseNext == PH_DRIVE && !hideNow) begin
      anNext = ~(8'h01 << dNext);
    end
  end

  bcd_to_seg u_dec (
    .bcd (nibble),
    .seg (decoded)
  );

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt   <= CNT_MAX;
      d     <= 3'd7;
      snap  <= 32'd0;
      an    <= 8'hFF;
      seg   <= SEG_BLANK;
      dp    <= 1'b1;
      frame <= 1'b0;
    end else begin
      cnt   <= cntNext;
      d     <= dNext;
      frame <= load;
      an    <= anNext;
      if (load) begin
        snap <= {hr, min, sec[23:8]};
      end
      if (cntNext == 16'd1) begin
        seg <= segNext;
        dp  <= ~DP_MASK[dNext];
      end
    end
  end

endmodule

// File: tb/tb_seg_scan.sv
// Directed bench for seg_scan with SCAN_DIV=8, BLANK_CYC=2; expected digit
// contents are queued per frame and checked as each slot is scanned.
module tb_seg_scan;

  localparam int SD = 8;
  localparam int BC = 2;
`ifdef SEG_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        clr;
  logic [23:0] sec;
  logic [7:0]  min;
  logic [7:0]  hr;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame;

  typedef struct {
    logic [6:0] seg;
    logic       dp;
    logic [7:0] anDrive;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  seg_scan #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
    .clk   (clk),
    .clr   (clr),
    .sec   (sec),
    .min   (min),
    .hr    (hr),
    .an    (an),
    .seg   (seg),
    .dp    (dp),
    .frame (frame)
  );

  function automatic logic [6:0] decodeRef(input logic [3:0] n);
    case (n)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      default: return 7'h3F;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] h, input logic [7:0] m, input logic [23:0] s);
    hr  = h;
    min = m;
    sec = s;
  endtask

  // Expected display for the values that the next load edge will capture
  task automatic pushFrame();
    logic [31:0] v;
    exp_t        e;
    v = {hr, min, sec[23:8]};
    for (int i = 0; i < 8; i++) begin
      e.seg     = decodeRef(v[i*4 +: 4]);
      e.dp      = !(i == 2 || i == 4 || i == 6);
      e.anDrive = ~(8'h01 << i);
      if (i == 7 && LZB && v[31:28] == 4'h0) begin
        e.seg     = 7'h7F;
        e.anDrive = 8'hFF;
      end
      sb.push_back(e);
    end
  endtask

  // Called at the negedge following a frame edge; returns at the next one
  task automatic checkFrame(input int changeK, input logic [7:0] newHr, input logic [7:0] newMin);
    exp_t e;
    int   c;
    e.seg = 7'h7F;
    e.dp = 1'b1;
    e.anDrive = 8'hFF;
    for (int k = 0; k < 8 * SD; k++) begin
      c = k % SD;
      if (k == changeK) applyStimulus(newHr, newMin, sec);
      checkOutput("frame", {7'b0, frame}, {7'b0, (k == 0)});
      if (c == 1) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $error("FAIL scoreboard observed=empty expected=entry at %0t", $time);
        end else begin
          e = sb.pop_front();
        end
        checkOutput("segLatency", {1'b0, seg}, {1'b0, e.seg});
      end
      if (c == SD - 1) begin
        checkOutput("segStable", {1'b0, seg}, {1'b0, e.seg});
        checkOutput("dp", {7'b0, dp}, {7'b0, e.dp});
      end
      checkOutput("an", an, (c < BC) ? 8'hFF : e.anDrive);
      checkOutput("anOnehot", {7'b0, ($countones(~an) <= 1)}, 8'd1);
      @(negedge clk);
    end
    checkOutput("framePeriod", {7'b0, frame}, 8'd1);
  endtask

  initial begin
    clr = 1'b1;
    applyStimulus(8'h12, 8'h34, 24'h567800);
    repeat (2) @(negedge clk);
    checkOutput("rstAn", an, 8'hFF);
    checkOutput("rstSeg", {1'b0, seg}, 8'h7F);
    checkOutput("rstDp", {7'b0, dp}, 8'd1);
    checkOutput("rstFrame", {7'b0, frame}, 8'd0);

    pushFrame();
    clr = 1'b0;
    @(negedge clk);
    checkFrame(-1, hr, min);

    pushFrame();
    checkFrame(20, 8'h12, 8'h35);

    pushFrame();
    checkFrame(10, 8'h1B, 8'h35);

    pushFrame();
    checkFrame(10, 8'h05, 8'h35);

    pushFrame();
    checkFrame(-1, hr, min);

    // Asynchronous clear in the middle of digit 3's drive window
    repeat (30) @(negedge clk);
    #2 clr = 1'b1;
    #1;
    checkOutput("clrAn", an, 8'hFF);
    checkOutput("clrSeg", {1'b0, seg}, 8'h7F);
    checkOutput("clrDp", {7'b0, dp}, 8'd1);
    checkOutput("clrFrame", {7'b0, frame}, 8'd0);
    @(negedge clk);
    applyStimulus(8'h23, 8'h59, 24'h480100);
    pushFrame();
    clr = 1'b0;
    @(negedge clk);
    checkFrame(-1, hr, min);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
